// File: rtl/seq_divider_axis.sv
// Signed fixed-point divider R = trunc(N * 2^F / D), one restoring step per clock.
// Operands arrive on two independent AXI-stream channels; the result is a one-cycle pulse.
//
// state  | meaning
// S_IDLE | collecting operands, both tready gated by have flags
// S_CALC | restoring division, one quotient bit per cycle
// S_SIGN | apply sign, saturation and divide-by-zero rules
// S_OUT  | load the output registers; tvalid pulses on the following cycle
module seq_divider_axis #(
   parameter int DIVIDEND_TDATA_WIDTH = 32,
   parameter int DIVISOR_TDATA_WIDTH  = 32,
   parameter int DIVOUT_F_WIDTH       = 16,
   parameter int DIVOUT_TDATA_WIDTH   = DIVIDEND_TDATA_WIDTH + DIVOUT_F_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DIVIDEND_TDATA_WIDTH-1:0] s_axis_dividend_tdata,
   input  logic                            s_axis_dividend_tvalid,
   output logic                            s_axis_dividend_tready,
   input  logic [DIVISOR_TDATA_WIDTH-1:0]  s_axis_divisor_tdata,
   input  logic                            s_axis_divisor_tvalid,
   output logic                            s_axis_divisor_tready,
   output logic [DIVOUT_TDATA_WIDTH-1:0]   m_axis_dout_tdata,
   output logic                            m_axis_dout_tuser,
   output logic                            m_axis_dout_tvalid,
   output logic                            busy
);
   localparam int NW = DIVIDEND_TDATA_WIDTH;
   localparam int DW = DIVISOR_TDATA_WIDTH;
   localparam int QW = DIVOUT_TDATA_WIDTH;
   localparam int RW = DW + 1;
   localparam int CW = $clog2(QW);
   localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
   localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};
   localparam logic [CW-1:0] CNT_LOAD = CW'(QW - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_OUT} state_t;

   state_t          state, state_nxt;
   logic            have_n, have_d;
   logic [NW-1:0]   n_q;
   logic [DW-1:0]   d_q;
   logic [RW-1:0]   d_mag_q;
   logic [QW-1:0]   num_q;
   logic [RW-1:0]   rem_q;
   logic [QW-1:0]   quot_q;
   logic [CW-1:0]   cnt_q;
   logic            sign_q, n_neg_q, dz_q;
   logic [QW-1:0]   res_q;
   logic            res_dz_q;

   logic            n_fire, d_fire, start;
   logic [NW-1:0]   n_op;
   logic [DW-1:0]   d_op;
   logic [NW:0]     n_ext, n_mag;
   logic [DW:0]     d_ext, d_mag;
   logic [RW:0]     rem_sh;
   logic            rem_ge;
   logic [RW-1:0]   rem_nxt;
   logic [QW-1:0]   res_nxt;

   assign s_axis_dividend_tready = (state == S_IDLE) & ~have_n;
   assign s_axis_divisor_tready  = (state == S_IDLE) & ~have_d;
   assign busy                   = (state != S_IDLE) | m_axis_dout_tvalid;

   assign n_fire = s_axis_dividend_tvalid & s_axis_dividend_tready;
   assign d_fire = s_axis_divisor_tvalid & s_axis_divisor_tready;
   assign start  = (state == S_IDLE) & (have_n | n_fire) & (have_d | d_fire);

   // An operand completing on the same edge is taken straight from the bus
   assign n_op  = have_n ? n_q : s_axis_dividend_tdata;
   assign d_op  = have_d ? d_q : s_axis_divisor_tdata;
   assign n_ext = {n_op[NW-1], n_op};
   assign d_ext = {d_op[DW-1], d_op};
   assign n_mag = n_ext[NW] ? -n_ext : n_ext;
   assign d_mag = d_ext[DW] ? -d_ext : d_ext;

   assign rem_sh = {rem_q, num_q[QW-1]};
   assign rem_ge = rem_sh >= {1'b0, d_mag_q};

   always_comb begin
      rem_nxt = rem_sh[RW-1:0];
      if (rem_ge) begin
         rem_nxt = RW'(rem_sh - {1'b0, d_mag_q});
      end
   end

   always_comb begin
      res_nxt = sign_q ? -quot_q : quot_q;
      if (dz_q) begin
         res_nxt = n_neg_q ? Q_MIN : Q_MAX;
      end else if (!sign_q && (quot_q == Q_MIN)) begin
         res_nxt = Q_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_CALC;
         S_CALC: if (cnt_q == '0) state_nxt = S_SIGN;
         S_SIGN: state_nxt = S_OUT;
         S_OUT:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         have_n             <= 1'b0;
         have_d             <= 1'b0;
         n_q                <= '0;
         d_q                <= '0;
         d_mag_q            <= '0;
         num_q              <= '0;
         rem_q              <= '0;
         quot_q             <= '0;
         cnt_q              <= '0;
         sign_q             <= 1'b0;
         n_neg_q            <= 1'b0;
         dz_q               <= 1'b0;
         res_q              <= '0;
         res_dz_q           <= 1'b0;
         m_axis_dout_tdata  <= '0;
         m_axis_dout_tuser  <= 1'b0;
         m_axis_dout_tvalid <= 1'b0;
      end else begin
         if (start) begin
            have_n  <= 1'b0;
            have_d  <= 1'b0;
            num_q   <= QW'({n_mag, {DIVOUT_F_WIDTH{1'b0}}});
            d_mag_q <= d_mag;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= CNT_LOAD;
            sign_q  <= n_op[NW-1] ^ d_op[DW-1];
            n_neg_q <= n_op[NW-1];
            dz_q    <= (d_op == '0);
         end else begin
            if (n_fire) begin
               n_q    <= s_axis_dividend_tdata;
               have_n <= 1'b1;
            end
            if (d_fire) begin
               d_q    <= s_axis_divisor_tdata;
               have_d <= 1'b1;
            end
         end

         if (state == S_CALC) begin
            rem_q  <= rem_nxt;
            num_q  <= {num_q[QW-2:0], 1'b0};
            quot_q <= {quot_q[QW-2:0], rem_ge};
            cnt_q  <= cnt_q - 1'b1;
         end

         if (state == S_SIGN) begin
            res_q    <= res_nxt;
            res_dz_q <= dz_q;
         end

         m_axis_dout_tvalid <= (state == S_OUT);
         if (state == S_OUT) begin
            m_axis_dout_tdata <= res_q;
            m_axis_dout_tuser <= res_dz_q;
         end
      end
   end
endmodule

// File: tb/tb_seq_divider_axis.sv
// Bench for seq_divider_axis: directed operand pairs, an arithmetic reference model
// and a per-cycle compare of tvalid/tdata/tuser/busy against the expected schedule.
module tb_seq_divider_axis;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_axis_dividend_tdata;
   logic        s_axis_dividend_tvalid;
   logic        s_axis_dividend_tready;
   logic [31:0] s_axis_divisor_tdata;
   logic        s_axis_divisor_tvalid;
   logic        s_axis_divisor_tready;
   logic [47:0] m_axis_dout_tdata;
   logic        m_axis_dout_tuser;
   logic        m_axis_dout_tvalid;
   logic        busy;

   seq_divider_axis dut (
      .clk                    (clk),
      .rst                    (rst),
      .s_axis_dividend_tdata  (s_axis_dividend_tdata),
      .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
      .s_axis_dividend_tready (s_axis_dividend_tready),
      .s_axis_divisor_tdata   (s_axis_divisor_tdata),
      .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
      .s_axis_divisor_tready  (s_axis_divisor_tready),
      .m_axis_dout_tdata      (m_axis_dout_tdata),
      .m_axis_dout_tuser      (m_axis_dout_tuser),
      .m_axis_dout_tvalid     (m_axis_dout_tvalid),
      .busy                   (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   typedef struct {
      int                 due;
      logic signed [31:0] n;
      logic signed [31:0] d;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // {tuser, tdata} from plain 64-bit arithmetic; integer division truncates toward zero
   function automatic logic [48:0] model(input logic signed [31:0] n, input logic signed [31:0] d);
      longint num, q;
      if (d == 0) return (n < 0) ? {1'b1, 48'h8000_0000_0000} : {1'b1, 48'h7FFF_FFFF_FFFF};
      num = longint'(n) * 64'sd65536;
      q   = num / longint'(d);
      if (q > 64'sh0000_7FFF_FFFF_FFFF) q = 64'sh0000_7FFF_FFFF_FFFF;
      return {1'b0, 48'(q)};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         logic       exp_tv;
         logic [48:0] m;
         exp_t        e;
         exp_tv = (exp_q.size() != 0) && (exp_q[0].due == cyc);
         check("busy", busy, exp_q.size() != 0);
         check("tvalid", m_axis_dout_tvalid, exp_tv);
         if (exp_tv) begin
            e = exp_q.pop_front();
            m = model(e.n, e.d);
            check("tdata", m_axis_dout_tdata, m[47:0]);
            check("tuser", m_axis_dout_tuser, m[48]);
         end
      end
   end

   task automatic send_both(input logic [31:0] n, input logic [31:0] d);
      @(negedge clk);
      s_axis_dividend_tdata  = n;
      s_axis_dividend_tvalid = 1'b1;
      s_axis_divisor_tdata   = d;
      s_axis_divisor_tvalid  = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back('{cyc + 50, n, d});
      s_axis_dividend_tvalid = 1'b0;
      s_axis_divisor_tvalid  = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("drain_timeout", exp_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_tvalid"}, m_axis_dout_tvalid, 0);
      check({tag, "_tdata"}, m_axis_dout_tdata, 0);
      check({tag, "_tuser"}, m_axis_dout_tuser, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_n_tready"}, s_axis_dividend_tready, 1);
      check({tag, "_d_tready"}, s_axis_divisor_tready, 1);
   endtask

   logic [31:0] tn [9] = '{32'd1, 32'hFFFF_FFF9, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB,
                           32'h8000_0000, 32'h8000_0000, 32'd6};
   logic [31:0] td [9] = '{32'd4, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0,
                           32'hFFFF_FFFF, 32'd1, 32'd3};
   logic [47:0] tr [9] = '{48'h0000_0000_4000, 48'hFFFF_FFFC_8000, 48'h0000_0000_5555,
                           48'hFFFF_FFFF_AAAB, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000,
                           48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 48'h0000_0002_0000};
   logic        tz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst                    = 1'b1;
      s_axis_dividend_tdata  = '0;
      s_axis_dividend_tvalid = 1'b0;
      s_axis_divisor_tdata   = '0;
      s_axis_divisor_tvalid  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst    = 1'b0;
      chk_en = 1'b1;

      for (int i = 0; i < 9; i++) begin
         check("model_pin", model(tn[i], td[i]), {tz[i], tr[i]});
      end

      for (int i = 0; i < 8; i++) begin
         send_both(tn[i], td[i]);
         wait_idle();
         check("dout_lit", {m_axis_dout_tuser, m_axis_dout_tdata}, {tz[i], tr[i]});
      end

      // Staggered operands, then a pair offered while busy must be dropped
      @(negedge clk);
      s_axis_dividend_tdata  = 32'd9;
      s_axis_dividend_tvalid = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      s_axis_dividend_tvalid = 1'b0;
      s_axis_dividend_tdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("n_tready_after_capture", s_axis_dividend_tready, 0);
      check("d_tready_waiting", s_axis_divisor_tready, 1);
      while (cyc < c0 + 4) @(negedge clk);
      check("n_tready_still_low", s_axis_dividend_tready, 0);
      s_axis_divisor_tdata  = 32'd4;
      s_axis_divisor_tvalid = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back('{cyc + 50, 32'sd9, 32'sd4});
      s_axis_divisor_tvalid = 1'b0;
      s_axis_divisor_tdata  = 32'h1234_5678;
      while (cyc < c0 + 19) @(negedge clk);
      s_axis_dividend_tdata  = 32'd100;
      s_axis_divisor_tdata   = 32'd7;
      s_axis_dividend_tvalid = 1'b1;
      s_axis_divisor_tvalid  = 1'b1;
      @(posedge clk);
      #1;
      s_axis_dividend_tvalid = 1'b0;
      s_axis_divisor_tvalid  = 1'b0;
      wait_idle();
      check("stagger_lit", {m_axis_dout_tuser, m_axis_dout_tdata}, {1'b0, 48'h0000_0002_4000});
      repeat (60) @(negedge clk);
      check("stagger_hold", {m_axis_dout_tuser, m_axis_dout_tdata}, {1'b0, 48'h0000_0002_4000});

      // Reset in the middle of a division aborts it
      send_both(32'd100, 32'd7);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("midrst");
      repeat (60) @(negedge clk);
      send_both(tn[8], td[8]);
      wait_idle();
      check("after_rst_lit", {m_axis_dout_tuser, m_axis_dout_tdata}, {tz[8], tr[8]});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
